// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, transaction owner,
// bus widths and the saturating starvation-counter step.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned BE_W     = 4;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT_GNT,
      ARB_WAIT_RVALID
   } arb_state_e;

   typedef enum logic {
      OWNER_IF,
      OWNER_LSU
   } mem_owner_e;

   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
      return (cnt == {STARVE_W{1'b1}}) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, LSU and memory-side handshake bundle of the memory port arbiter.
// The arbiter uses the master view; the surrounding core/memory uses the slave view.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              if_req_ip;
   logic [ADDR_W-1:0] if_addr_ip;
   logic              if_gnt_op;
   logic              if_rvalid_op;
   logic [DATA_W-1:0] if_rdata_op;

   logic              lsu_req_ip;
   logic              lsu_we_ip;
   logic [BE_W-1:0]   lsu_be_ip;
   logic [ADDR_W-1:0] lsu_addr_ip;
   logic [DATA_W-1:0] lsu_wdata_ip;
   logic              lsu_gnt_op;
   logic              lsu_rvalid_op;
   logic [DATA_W-1:0] lsu_rdata_op;

   logic              flush_ip;

   logic              mem_req_op;
   logic              mem_we_op;
   logic [BE_W-1:0]   mem_be_op;
   logic [ADDR_W-1:0] mem_addr_op;
   logic [DATA_W-1:0] mem_wdata_op;
   logic              mem_gnt_ip;
   logic              mem_rvalid_ip;
   logic [DATA_W-1:0] mem_rdata_ip;

   logic              busy_op;

   modport master (
      input  if_req_ip, if_addr_ip,
      input  lsu_req_ip, lsu_we_ip, lsu_be_ip, lsu_addr_ip, lsu_wdata_ip,
      input  flush_ip, mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
      output if_gnt_op, if_rvalid_op, if_rdata_op,
      output lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
      output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
      output busy_op
   );

   modport slave (
      output if_req_ip, if_addr_ip,
      output lsu_req_ip, lsu_we_ip, lsu_be_ip, lsu_addr_ip, lsu_wdata_ip,
      output flush_ip, mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
      input  if_gnt_op, if_rvalid_op, if_rdata_op,
      input  lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
      input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
      input  busy_op
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises Fetch and LSU onto the single memory port, one transaction in flight,
// LSU-priority with a starvation override for Fetch and flush-driven fetch drop.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clock,
   input logic               reset,
   mem_port_arbiter_if.master bus
);

   localparam logic [STARVE_W-1:0] STARVE_LIMIT_C = STARVE_W'(STARVE_LIMIT);

   arb_state_e          state, state_nxt;
   mem_owner_e          owner;
   logic                drop;
   logic [STARVE_W-1:0] starve_cnt;
   logic                if_gnt, lsu_gnt, if_eff, starved;

   logic                mem_req, mem_we;
   logic [BE_W-1:0]     mem_be;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                if_rvalid, lsu_rvalid;
   logic [DATA_W-1:0]   if_rdata, lsu_rdata;

   // A flushing Fetch is treated as absent, so the LSU can still win that cycle.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      lsu_gnt   = 1'b0;
      if_eff    = bus.if_req_ip && !bus.flush_ip;
      starved   = if_eff && (starve_cnt >= STARVE_LIMIT_C);
      case (state)
         ARB_IDLE: begin
            if (reset) begin
               if (bus.lsu_req_ip && !starved) lsu_gnt = 1'b1;
               else if (if_eff)                if_gnt  = 1'b1;
               if (lsu_gnt || if_gnt) state_nxt = ARB_WAIT_GNT;
            end
         end
         ARB_WAIT_GNT:    if (bus.mem_gnt_ip)    state_nxt = ARB_WAIT_RVALID;
         ARB_WAIT_RVALID: if (bus.mem_rvalid_ip) state_nxt = ARB_IDLE;
         default:                                state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         owner      <= OWNER_IF;
         drop       <= 1'b0;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rvalid  <= 1'b0;
         lsu_rvalid <= 1'b0;
         if_rdata   <= '0;
         lsu_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         if_rvalid  <= 1'b0;
         lsu_rvalid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (lsu_gnt) begin
                  owner     <= OWNER_LSU;
                  mem_req   <= 1'b1;
                  mem_we    <= bus.lsu_we_ip;
                  mem_be    <= bus.lsu_be_ip;
                  mem_addr  <= bus.lsu_addr_ip;
                  mem_wdata <= bus.lsu_wdata_ip;
                  drop      <= 1'b0;
                  if (bus.if_req_ip) starve_cnt <= starve_inc(starve_cnt);
               end else if (if_gnt) begin
                  owner      <= OWNER_IF;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_be     <= {BE_W{1'b1}};
                  mem_addr   <= bus.if_addr_ip;
                  mem_wdata  <= '0;
                  drop       <= 1'b0;
                  starve_cnt <= '0;
               end
            end
            ARB_WAIT_GNT: begin
               if (bus.mem_gnt_ip) mem_req <= 1'b0;
               if (owner == OWNER_IF && bus.flush_ip) drop <= 1'b1;
            end
            ARB_WAIT_RVALID: begin
               if (bus.mem_rvalid_ip) begin
                  drop <= 1'b0;
                  if (owner == OWNER_LSU) begin
                     lsu_rvalid <= 1'b1;
                     lsu_rdata  <= bus.mem_rdata_ip;
                  end else if (!(drop || bus.flush_ip)) begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= bus.mem_rdata_ip;
                  end
               end else if (owner == OWNER_IF && bus.flush_ip) begin
                  drop <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.if_gnt_op     = if_gnt;
   assign bus.lsu_gnt_op    = lsu_gnt;
   assign bus.if_rvalid_op  = if_rvalid;
   assign bus.if_rdata_op   = if_rdata;
   assign bus.lsu_rvalid_op = lsu_rvalid;
   assign bus.lsu_rdata_op  = lsu_rdata;
   assign bus.mem_req_op    = mem_req;
   assign bus.mem_we_op     = mem_we;
   assign bus.mem_be_op     = mem_be;
   assign bus.mem_addr_op   = mem_addr;
   assign bus.mem_wdata_op  = mem_wdata;
   assign bus.busy_op       = (state != ARB_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single unified memory port between the Fetch stage (instruction reads) and the LSU (data loads/stores) in the 5-stage RV32I pipeline. It serialises one outstanding transaction at a time. LSU has priority, and a starvation counter guarantees Fetch progress. It honours pipeline flush by discarding the response of an in-flight fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants with Fetch waiting before Fetch is forced to win. Legal range 1–15.

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- if_req_ip  in  1  Fetch read request. Held with address until granted.
- if_addr_ip  in  32  Fetch word address.
- if_gnt_op  out  1  Fetch request accepted this cycle.
- if_rvalid_op  out  1  Instruction data valid, one-cycle pulse.
- if_rdata_op  out  32  Instruction data.
- lsu_req_ip  in  1  LSU request. Held with its attributes until granted.
- lsu_we_ip  in  1  1 = store, 0 = load.
- lsu_be_ip  in  4  Byte enables.
- lsu_addr_ip  in  32  Data address.
- lsu_wdata_ip  in  32  Store data.
- lsu_gnt_op  out  1  LSU request accepted this cycle.
- lsu_rvalid_op  out  1  Load data valid or store acknowledged, one-cycle pulse.
- lsu_rdata_op  out  32  Load data.
- flush_ip  in  1  Pipeline flush from EX.
- mem_req_op, mem_we_op  out  1 each  Memory request and write enable.
- mem_be_op  out  4  Memory byte enables.
- mem_addr_op, mem_wdata_op  out  32 each  Memory address and write data.
- mem_gnt_ip  in  1  Memory accepted the request.
- mem_rvalid_ip  in  1  Memory response valid. Also asserted for writes.
- mem_rdata_ip  in  32  Memory read data.
- busy_op  out  1  A transaction is in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE → WAIT_GNT → WAIT_RVALID → IDLE.
- IDLE selection (combinational gnt):
  - LSU wins if lsu_req_ip=1, unless if_req_ip=1 and starve_cnt ≥ STARVE_LIMIT.
  - Otherwise Fetch wins if if_req_ip=1.
  - if_gnt_op is suppressed in a cycle where flush_ip=1; in that cycle the LSU may still be granted.
- On grant, register the following, then go to WAIT_GNT:
  - owner (IF/LSU)
  - mem_addr_op, mem_we_op, mem_be_op, mem_wdata_op
  - For Fetch: we=0 and be=4'hF.
- WAIT_GNT:
  - mem_req_op=1 with stable attributes.
  - On mem_gnt_ip=1: mem_req_op deasserts next cycle and the FSM goes to WAIT_RVALID.
- WAIT_RVALID:
  - On mem_rvalid_ip=1: register rdata to the owner's rdata output and pulse the owner's rvalid next cycle, then go to IDLE.
  - If drop=1, the Fetch rvalid is not pulsed and drop clears.
- Flush:
  - flush_ip=1 while the owner is Fetch in WAIT_GNT or WAIT_RVALID sets drop.
  - The memory transaction still completes; it is never aborted.
  - Flush has no effect on an LSU-owned transaction.
- starve_cnt (4 bits):
  - Increments, saturating at 15, on each LSU grant while if_req_ip=1.
  - Clears on a Fetch grant.
  - Holds otherwise.
- mem_rvalid_ip outside WAIT_RVALID and mem_gnt_ip outside WAIT_GNT are ignored.
- if_rdata_op and lsu_rdata_op hold their last value between pulses.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; starve_cnt=0; drop=0.
  - All outputs 0; mem_req_op drops in the same cycle reset asserts.
  - A transaction in flight at reset is abandoned.
  - Any response arriving after reset release is ignored, because the FSM is in IDLE.
- Minimum latency for a request at cycle t with zero-wait memory:
  - gnt at t
  - mem_req_op at t+1
  - mem_gnt_ip and mem_rvalid_ip at t+1 and t+2
  - owner rvalid at t+3
  - the next grant is possible at t+3
- Peak throughput is one transaction per 3 cycles.
- Simultaneous requests in IDLE: exactly one gnt is asserted. Both gnts are never high together.
- flush_ip in the same cycle as mem_rvalid_ip (Fetch owner): the response is dropped.
- Fetch starvation bound: with continuous LSU requests, Fetch is granted at latest on the (STARVE_LIMIT+1)th arbitration.

## Structure
- CORE_PKG additions:
  - typedef enum arb_state_e {ARB_IDLE, ARB_WAIT_GNT, ARB_WAIT_RVALID}
  - typedef enum mem_owner_e {OWNER_IF, OWNER_LSU}
- Single module, no sub-modules. Selection logic is combinational; FSM, request register, response register and counters are in one always_ff with asynchronous negedge reset.

## Test plan
- Fetch-only read: if_req_ip=1, if_addr_ip=0x100; memory returns 0x00000013 with zero wait → if_gnt_op at t, mem_addr_op=0x100 at t+1, if_rvalid_op with 0x13 at t+3.
- LSU store to 0x2000, be=4'b0011, wdata=0xBEEF, mem_gnt_ip delayed 3 cycles → mem_req_op held 4 cycles with stable attributes, mem_we_op=1, lsu_rvalid_op pulses once after rvalid.
- Continuous lsu_req_ip and if_req_ip, STARVE_LIMIT=4 → grant order LSU×4, IF, LSU×4, IF; never two gnts in one cycle.
- Fetch in WAIT_RVALID, flush_ip pulsed, memory returns 0xDEADBEEF → no if_rvalid_op pulse, busy_op falls, next if_req_ip is served normally.
- Reset asserted during WAIT_GNT of an LSU load → all outputs 0 immediately; a stale mem_rvalid_ip after release produces no lsu_rvalid_op pulse.
